bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 45 ++++
 rtl/bus_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_arbiter_if
//   Signal bundle between the four requesters and the bus arbiter.
//
//   Handshake: req[i] is a level request held by requester i for as long as it
//   wants the bus. grant is the arbiter's registered one-hot answer. A
//   requester owns the bus in every cycle where its grant bit is 1 and gives
//   the bus up by dropping its req bit. Neither side waits on the other within
//   a cycle. A grant may also be withdrawn while req is still high, and
//   preempt marks that cycle.
//
//   Signals
//     req     [3:0]  requesters -> arbiter, per-requester request
//     grant   [3:0]  arbiter -> requesters, one-hot grant, 0 when idle
//     owner   [1:0]  arbiter -> requesters, index of current/last grantee
//     busy           arbiter -> requesters, 1 iff grant != 0
//     preempt        arbiter -> requesters, one-cycle forced-handover pulse
//
//   Modports
//     master  requester side (drives req)
//     slave   arbiter side   (drives grant/owner/busy/preempt)
// ----------------------------------------------------------------------------
interface bus_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;

    modport master (
        output req,
        input  grant,
        input  owner,
        input  busy,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output owner,
        output busy,
        output preempt
    );
endinterface

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//   Four-requester round-robin bus arbiter with registered one-hot grant.
//   The winner search starts one past the most recently granted index and
//   wraps. The owner keeps the bus while its req stays high. When the owner
//   drops req while others are waiting, the bus moves on at the same edge.
//
//   Optional feature, enabled by defining BUS_ARBITER_TIMEOUT_EN:
//     A hold counter limits a single grant to HOLD_MAX consecutive cycles
//     whenever another requester is waiting. The forced handover is flagged
//     by a one-cycle preempt pulse. Without the macro there is no counter
//     and preempt is always 0.
//
//   Parameters
//     HOLD_MAX     maximum consecutive grant cycles before preemption (2..15)
//
//   Ports
//     clk          system clock, rising edge
//     reset        asynchronous active-high reset
//     bus          bus_arbiter_if.slave: req in; grant/owner/busy/preempt out
//     state_dbg_o  current FSM state (0 = IDLE, 1 = GRANT)
// ----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic           clk,
    input  logic           reset,
    bus_arbiter_if.slave   bus,
    output logic           state_dbg_o
);

    if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_bad_hold_max
        $error("bus_arbiter: HOLD_MAX must be in 2..15");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Round-robin pick. Rotate req so that index 'start' lands at bit 0.
    // Take the lowest set bit of the rotated vector, then add 'start' back
    // (mod 4). The caller only uses the result when r != 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [1:0] k;
        dbl = {r, r} >> start;
        rot = dbl[3:0];
        k   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) k = i[1:0];
        end
        return start + k;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q,  last_d;
    logic       busy_q,  busy_d;
    logic       preempt_q, preempt_d;

    logic [3:0] owner_oh;
    logic [3:0] others_req;
    logic [1:0] win_idle;
    logic [1:0] win_next;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
    logic [3:0] hold_q, hold_d;
`endif

    assign owner_oh   = 4'b0001 << owner_q;
    // With req[owner] low, others_req equals req. So one search serves both
    // the voluntary and the forced handover.
    assign others_req = bus.req & ~owner_oh;
    assign win_idle   = rr_pick(bus.req, last_q + 2'd1);
    assign win_next   = rr_pick(others_req, owner_q + 2'd1);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        preempt_d = 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << win_idle;
                    owner_d = win_idle;
                    last_d  = win_idle;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    hold_d  = 4'd0;
`endif
                end
            end
            GRANT: begin
                if (bus.req == 4'b0000) begin
                    // Owner and last keep their values while idle.
                    state_d = IDLE;
                    grant_d = 4'b0000;
                end else if (!bus.req[owner_q]) begin
                    grant_d = 4'b0001 << win_next;
                    owner_d = win_next;
                    last_d  = win_next;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    hold_d  = 4'd0;
`endif
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (hold_q == HOLD_LAST && (|others_req)) begin
                    grant_d   = 4'b0001 << win_next;
                    owner_d   = win_next;
                    last_d    = win_next;
                    preempt_d = 1'b1;
                    hold_d    = 4'd0;
                end else begin
                    // Saturate so that preemption fires at the first edge
                    // where another request appears.
                    if (hold_q != HOLD_LAST) hold_d = hold_q + 4'd1;
                end
`else
                else begin
                    grant_d = grant_q;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            owner_q   <= 2'd0;
            last_q    <= 2'd3;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            hold_q    <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign bus.grant   = grant_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;
    assign state_dbg_o = state_q;

endmodule
